// File: rtl/updown_mode_ctrl.sv
// ----------------------------------------------------------------------------
// updown_mode_ctrl
//
// Control stage that sits in front of the 4-bit T-flip-flop up/down counter.
// It produces two signals for the counter:
//   - tick_out, a divided count clock. The counter acts on its falling edge.
//   - M, the counting direction (0 = up, 1 = down).
//
// Button handling:
//   - A raw push-button is synchronised and then debounced.
//   - Each confirmed press is remembered as "pending".
//   - A pending press toggles M only on a rising edge of tick_out. The
//     counter's negedge-triggered stages therefore never see M move in the
//     middle of a count phase.
//
// Parameters
//   DIV        half-period of tick_out in clk cycles (>= 1)
//   DEB_CYCLES stable synced-button cycles needed to confirm a level (>= 1)
//   CNT_W      width of the prescaler and debounce counters
//
// Ports
//   clk       in   system clock, all state changes on its rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_raw   in   raw mode-toggle button (asynchronous, may bounce)
//   hold      in   1 = freeze the prescaler and tick_out
//   tick_out  out  divided count clock, driven straight from a flop
//   M         out  counter mode, 0 = up, 1 = down
//   mode_chg  out  one-cycle pulse in the cycle M takes its new value
// ----------------------------------------------------------------------------
module updown_mode_ctrl #(
   parameter int DIV        = 4,
   parameter int DEB_CYCLES = 3,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   input  logic hold,
   output logic tick_out,
   output logic M,
   output logic mode_chg
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CNT = 2'd1,
      PRESSED   = 2'd2,
      REL_CNT   = 2'd3
   } deb_state_t;

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] DEB_TGT  = CNT_W'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             btn_meta;
   logic             btn_s;
   logic [CNT_W-1:0] presc;
   logic             tick_rise;
   deb_state_t       deb_state;
   deb_state_t       deb_state_nxt;
   logic [CNT_W-1:0] deb_cnt;
   logic [CNT_W-1:0] deb_cnt_nxt;
   logic [CNT_W-1:0] deb_cnt_inc;
   logic             pressed;
   logic             pending;

   // Two-flop synchroniser for the asynchronous button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         btn_meta <= btn_raw;
         btn_s    <= btn_meta;
      end
   end

   // Prescaler. tick_out is a plain flop output, so it cannot glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         tick_out <= 1'b0;
      end else if (!hold) begin
         if (presc == DIV_LAST) begin
            presc    <= '0;
            tick_out <= ~tick_out;
         end else begin
            presc <= presc + CNT_ONE;
         end
      end
   end

   // High in the cycle whose closing edge takes tick_out from 0 to 1.
   assign tick_rise = !hold && (presc == DIV_LAST) && !tick_out;

   // Debounce FSM: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_state <= IDLE;
         deb_cnt   <= '0;
      end else begin
         deb_state <= deb_state_nxt;
         deb_cnt   <= deb_cnt_nxt;
      end
   end

   assign deb_cnt_inc = deb_cnt + CNT_ONE;

   // Debounce FSM: next state and decoded outputs.
   // The counter holds the number of consecutive cycles already seen at the
   // candidate level. It moves on in the same cycle the incremented value
   // reaches DEB_CYCLES.
   always_comb begin
      deb_state_nxt = deb_state;
      deb_cnt_nxt   = deb_cnt;
      pressed       = 1'b0;
      case (deb_state)
         IDLE: begin
            if (btn_s) begin
               deb_state_nxt = PRESS_CNT;
               deb_cnt_nxt   = CNT_ONE;
            end
         end
         PRESS_CNT: begin
            if (!btn_s) begin
               deb_state_nxt = IDLE;
               deb_cnt_nxt   = '0;
            end else begin
               deb_cnt_nxt = deb_cnt_inc;
               if (deb_cnt_inc >= DEB_TGT) begin
                  deb_state_nxt = PRESSED;
               end
            end
         end
         PRESSED: begin
            pressed       = 1'b1;
            deb_state_nxt = REL_CNT;
            deb_cnt_nxt   = '0;
         end
         REL_CNT: begin
            if (btn_s) begin
               deb_cnt_nxt = '0;
            end else if (deb_cnt_inc >= DEB_TGT) begin
               deb_state_nxt = IDLE;
               deb_cnt_nxt   = '0;
            end else begin
               deb_cnt_nxt = deb_cnt_inc;
            end
         end
         default: begin
            deb_state_nxt = IDLE;
            deb_cnt_nxt   = '0;
         end
      endcase
   end

   // Mode register.
   // Presses arriving while one is already pending merge into that one.
   // A press confirmed on the same edge as a tick rise only sets pending;
   // the toggle waits for the following rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         M        <= 1'b0;
         mode_chg <= 1'b0;
         pending  <= 1'b0;
      end else begin
         mode_chg <= tick_rise && pending;
         if (tick_rise && pending) begin
            M <= ~M;
         end
         pending <= (pending && !tick_rise) || pressed;
      end
   end

endmodule

// File: tb/tb_updown_mode_ctrl.sv
`timescale 1ns/1ps
module tb_updown_mode_ctrl;

   localparam int DIV      = 4;
   localparam int DEB      = 3;
   localparam int DIV_SLOW = 40;
   // Earliest edge a toggle may happen, counted from the negedge where the
   // button is raised:
   //   1 edge to sample the button
   //   + 2 edges through the synchroniser
   //   + DEB edges to confirm the press
   //   + 1 edge to set pending, so the next edge is the earliest toggle.
   localparam int PEND_LAT = DEB + 4;

   logic clk       = 1'b0;
   logic rst_n     = 1'b1;
   logic btn_raw   = 1'b0;
   logic hold      = 1'b0;
   logic btn_slow  = 1'b0;
   logic hold_slow = 1'b0;
   logic tick_out, m, mode_chg;
   logic tick_slow, m_slow, chg_slow;

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   logic m_model   = 1'b0;
   logic m_s_model = 1'b0;
   logic [0:0] exp_q[$];
   int         exp_edge_q[$];
   logic [0:0] exp_s_q[$];
   int         exp_s_edge_q[$];
   int         rise_q[$];
   int         rise_s_q[$];
   logic       prev_tick   = 1'b0;
   logic       prev_tick_s = 1'b0;

   updown_mode_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .hold(hold),
      .tick_out(tick_out), .M(m), .mode_chg(mode_chg)
   );

   updown_mode_ctrl #(.DIV(DIV_SLOW), .DEB_CYCLES(DEB), .CNT_W(8)) dut_slow (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_slow), .hold(hold_slow),
      .tick_out(tick_slow), .M(m_slow), .mode_chg(chg_slow)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- check ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboards ----------------
   logic [0:0] mon_exp;
   int         mon_edge;
   int         mon_early;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_tick = 1'b0;
      end else begin
         if (tick_out && !prev_tick) rise_q.push_back(cyc);
         if (mode_chg) begin
            if (exp_q.size() == 0) begin
               check("unexp_chg", 32'(mode_chg), 32'd0);
            end else begin
               mon_exp   = exp_q.pop_front();
               mon_edge  = exp_edge_q.pop_front();
               mon_early = 0;
               foreach (rise_q[i]) if (rise_q[i] >= mon_edge && rise_q[i] < cyc) mon_early++;
               check("m_value", 32'(m), 32'(mon_exp));
               check("chg_on_rise", 32'(tick_out && !prev_tick), 32'd1);
               check("first_rise_after_pend", 32'(mon_early), 32'd0);
               check("not_before_pend", 32'(cyc >= mon_edge), 32'd1);
            end
         end
         prev_tick = tick_out;
      end
   end

   logic [0:0] mon_s_exp;
   int         mon_s_edge;
   int         mon_s_early;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_tick_s = 1'b0;
      end else begin
         if (tick_slow && !prev_tick_s) rise_s_q.push_back(cyc);
         if (chg_slow) begin
            if (exp_s_q.size() == 0) begin
               check("slow_unexp_chg", 32'(chg_slow), 32'd0);
            end else begin
               mon_s_exp   = exp_s_q.pop_front();
               mon_s_edge  = exp_s_edge_q.pop_front();
               mon_s_early = 0;
               foreach (rise_s_q[i]) if (rise_s_q[i] >= mon_s_edge && rise_s_q[i] < cyc) mon_s_early++;
               check("slow_m_value", 32'(m_slow), 32'(mon_s_exp));
               check("slow_chg_on_rise", 32'(tick_slow && !prev_tick_s), 32'd1);
               check("slow_first_rise", 32'(mon_s_early), 32'd0);
            end
         end
         prev_tick_s = tick_slow;
      end
   end

   // ---------------- driver tasks ----------------
   // All of these are entered and left on a negedge of clk.
   task automatic expect_toggle(input bit slow);
      if (slow) begin
         m_s_model = ~m_s_model;
         exp_s_q.push_back(m_s_model);
         exp_s_edge_q.push_back(cyc + PEND_LAT);
      end else begin
         m_model = ~m_model;
         exp_q.push_back(m_model);
         exp_edge_q.push_back(cyc + PEND_LAT);
      end
   endtask

   task automatic press(input bit slow, input int hi, input int lo);
      if (slow) btn_slow = 1'b1; else btn_raw = 1'b1;
      repeat (hi) @(negedge clk);
      if (slow) btn_slow = 1'b0; else btn_raw = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   // Waits for tick_out (or tick_slow) to change to lvl; n = negedges taken.
   task automatic wait_edge(input bit slow, input logic lvl, input int budget,
                            input string tag, output int n);
      logic p, t;
      bit   seen;
      seen = 1'b0;
      p    = slow ? tick_slow : tick_out;
      t    = p;
      n    = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         n++;
         t = slow ? tick_slow : tick_out;
         if (t === lvl && p !== lvl) seen = 1'b1;
         p = t;
      end
      if (!seen) check(tag, 32'(seen), 32'd1);
   endtask

   task automatic measure_phase(input logic lvl, output int len);
      bit done;
      done = 1'b0;
      len  = 1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (tick_out !== lvl) done = 1'b1;
         else len++;
      end
   endtask

   task automatic drain(input bit slow, input int budget, input string tag);
      int n;
      n = 0;
      while ((slow ? exp_s_q.size() : exp_q.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(slow ? exp_s_q.size() : exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int   n, hi, lo;
      logic m_prev;

      // Reset: asynchronous assertion, checked before any clk edge.
      #1 rst_n = 1'b0;
      #2;
      check("rst_tick", 32'(tick_out), 32'd0);
      check("rst_m", 32'(m), 32'd0);
      check("rst_chg", 32'(mode_chg), 32'd0);
      check("rst_tick_slow", 32'(tick_slow), 32'd0);
      check("rst_m_slow", 32'(m_slow), 32'd0);
      #19 rst_n = 1'b1;
      wait_edge(1'b0, 1'b1, 10, "rst_rise_timeout", n);
      check("rst_rise_lat", 32'(n), 32'(DIV));

      // 1: free run.
      for (int i = 0; i < 2; i++) begin
         measure_phase(1'b1, hi);
         measure_phase(1'b0, lo);
         check("t1_high", 32'(hi), 32'(DIV));
         check("t1_low", 32'(lo), 32'(DIV));
      end
      check("t1_m", 32'(m), 32'd0);

      // 2: one long clean press.
      expect_toggle(1'b0);
      press(1'b0, 12, 1);
      drain(1'b0, 40, "t2_drain");
      repeat (20) @(negedge clk);
      check("t2_m", 32'(m), 32'(m_model));

      // 3: single-cycle bounces never confirm.
      for (int i = 0; i < 3; i++) press(1'b0, 1, 1);
      repeat (30) @(negedge clk);
      check("t3_m", 32'(m), 32'(m_model));

      // 4: hold applied just before the first rise after pending.
      wait_edge(1'b0, 1'b1, 20, "t4_sync_timeout", n);
      m_prev = m_model;
      expect_toggle(1'b0);
      press(1'b0, 6, 1);
      hold = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t4_hold_tick", 32'(tick_out), 32'd0);
         check("t4_hold_m", 32'(m), 32'(m_prev));
      end
      hold = 1'b0;
      drain(1'b0, 10, "t4_drain");
      check("t4_m", 32'(m), 32'(m_model));

      // 5: two presses inside one long low phase give one toggle.
      wait_edge(1'b1, 1'b0, 100, "t5_sync_timeout", n);
      expect_toggle(1'b1);
      press(1'b1, 6, 6);
      press(1'b1, 6, 6);
      drain(1'b1, 100, "t5_drain");
      check("t5_m", 32'(m_slow), 32'(m_s_model));
      repeat (100) @(negedge clk);
      check("t5_m_stable", 32'(m_slow), 32'(m_s_model));

      // 6: bring M to 1, then reset in a high phase with a press pending.
      expect_toggle(1'b0);
      press(1'b0, 8, 4);
      drain(1'b0, 40, "t6_pre_drain");
      check("t6_pre_m", 32'(m), 32'(m_model));
      wait_edge(1'b0, 1'b0, 20, "t6_sync_timeout", n);
      press(1'b0, 6, 0);
      #2 rst_n = 1'b0;
      #1;
      m_model   = 1'b0;
      m_s_model = 1'b0;
      check("t6_rst_tick", 32'(tick_out), 32'd0);
      check("t6_rst_m", 32'(m), 32'(m_model));
      check("t6_rst_chg", 32'(mode_chg), 32'd0);
      check("t6_rst_m_slow", 32'(m_slow), 32'(m_s_model));
      @(negedge clk);
      #2 rst_n = 1'b1;
      wait_edge(1'b0, 1'b1, 10, "t6_rise_timeout", n);
      check("t6_rise_lat", 32'(n), 32'(DIV));
      repeat (40) @(negedge clk);
      check("t6_m", 32'(m), 32'(m_model));

      check("q_empty", 32'(exp_q.size() + exp_s_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
